// File: rtl/adder_mon_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   DEF_*      default sum/counter/accumulator widths and window length
//   rpt_rec_t  one window report (samples, errors, max_ed, sum_ed) at default widths
//   sat_add    unsigned add that clips to an all-ones value of width w (w <= SAT_MAX_W)
package adder_mon_pkg;

  localparam int DEF_W      = 33;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_WINDOW = 1024;
  localparam int SAT_MAX_W  = 64;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] samples;
    logic [DEF_CNT_W-1:0] errors;
    logic [DEF_W-1:0]     max_ed;
    logic [DEF_ACC_W-1:0] sum_ed;
  } rpt_rec_t;

  // Operands are zero-extended into a SAT_MAX_W container; the result is
  // clipped to 2^w - 1 once the true sum reaches 2^w.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] a,
    input logic [SAT_MAX_W-1:0] b,
    input int unsigned          w
  );
    logic [SAT_MAX_W:0] s;
    logic [SAT_MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (SAT_MAX_W+1)'(1) << w;
    if (s >= lim) return {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - w);
    return s[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/adder_error_monitor_err_dist_stage.sv
// First pipeline stage of the error monitor: error distance |approx - exact|
// and a nonzero flag, registered together with a valid bit.
//   clk, rst, clear     clock, sync reset, sync flush (both empty the stage)
//   in_vld              a sample is accepted this cycle
//   approx_sum/exact_sum  operand sums (DATA_W bits, unsigned)
//   vld_p1/ed_p1/flag_p1  registered valid, error distance and ED != 0
module err_dist_stage #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] approx_sum,
  input  logic [DATA_W-1:0] exact_sum,
  output logic              vld_p1,
  output logic [DATA_W-1:0] ed_p1,
  output logic              flag_p1
);

  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]      ed;

  // One extra bit keeps the signed difference exact; its magnitude always
  // fits back into DATA_W bits.
  always_comb begin
    diff = $signed({1'b0, approx_sum}) - $signed({1'b0, exact_sum});
    ed   = diff[DATA_W] ? DATA_W'(-diff) : DATA_W'(diff);
  end

  // ---- stage p1 ----
  always_ff @(posedge clk) begin
    if (rst || clear) vld_p1 <= 1'b0;
    else              vld_p1 <= in_vld;
  end

  always_ff @(posedge clk) begin
    if (in_vld) begin
      ed_p1   <= ed;
      flag_p1 <= |ed;
    end
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Error monitor for the approximate adder under test. Each accepted sample
// yields ED = |approx - exact|; per WINDOW samples it reports sample count,
// mismatch count, max ED and saturating sum of ED over a valid/ready handshake.
//   clk, rst, clear          clock, sync active-high reset, sync flush
//   in_valid/in_ready        sample handshake (approx_sum, exact_sum)
//   rpt_valid/rpt_ready      report handshake
//   rpt_samples, rpt_errors  CNT_W counters of the closed window
//   rpt_max_ed, rpt_sum_ed   largest ED (W) and saturating ED sum (ACC_W)
module adder_error_monitor
  import adder_mon_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     approx_sum,
  input  logic [W-1:0]     exact_sum,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_samples,
  output logic [CNT_W-1:0] rpt_errors,
  output logic [W-1:0]     rpt_max_ed,
  output logic [ACC_W-1:0] rpt_sum_ed
);

  logic             accept;
  logic             vld_p1;
  logic [W-1:0]     ed_p1;
  logic             flag_p1;

  logic [CNT_W-1:0] cnt_p2, err_p2;
  logic [W-1:0]     max_p2;
  logic [ACC_W-1:0] sum_p2;

  logic [CNT_W-1:0] cnt_nxt, err_nxt;
  logic [W-1:0]     max_nxt;
  logic [ACC_W-1:0] sum_nxt;
  logic             close;

  // A pending, unaccepted report blocks new samples. At most the one sample
  // already in p1 can still land, and WINDOW >= 2 keeps it from closing a
  // second window before the first is taken.
  assign in_ready = !rst && (!rpt_valid || rpt_ready);
  assign accept   = in_valid && in_ready;

  err_dist_stage #(
    .DATA_W(W)
  ) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_vld     (accept),
    .approx_sum (approx_sum),
    .exact_sum  (exact_sum),
    .vld_p1     (vld_p1),
    .ed_p1      (ed_p1),
    .flag_p1    (flag_p1)
  );

  always_comb begin
    cnt_nxt = cnt_p2 + CNT_W'(1);
    err_nxt = err_p2 + CNT_W'(flag_p1);
    max_nxt = (ed_p1 > max_p2) ? ed_p1 : max_p2;
    sum_nxt = ACC_W'(sat_add(SAT_MAX_W'(sum_p2), SAT_MAX_W'(ed_p1), ACC_W));
    close   = (cnt_nxt == CNT_W'(WINDOW));
  end

  // ---- stage p2: accumulate, close window, report handshake ----
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_p2      <= '0;
      err_p2      <= '0;
      max_p2      <= '0;
      sum_p2      <= '0;
      rpt_valid   <= 1'b0;
      rpt_samples <= '0;
      rpt_errors  <= '0;
      rpt_max_ed  <= '0;
      rpt_sum_ed  <= '0;
    end else begin
      if (rpt_valid && rpt_ready) rpt_valid <= 1'b0;
      if (vld_p1) begin
        if (close) begin
          // Closing sample is included in the report; a report retiring on
          // this same edge is replaced, so rpt_valid stays high.
          rpt_samples <= cnt_nxt;
          rpt_errors  <= err_nxt;
          rpt_max_ed  <= max_nxt;
          rpt_sum_ed  <= sum_nxt;
          rpt_valid   <= 1'b1;
          cnt_p2      <= '0;
          err_p2      <= '0;
          max_p2      <= '0;
          sum_p2      <= '0;
        end else begin
          cnt_p2 <= cnt_nxt;
          err_p2 <= err_nxt;
          max_p2 <= max_nxt;
          sum_p2 <= sum_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed bench for adder_error_monitor: small-window instances for the
// hand-computed cases, a narrow-accumulator instance for saturation, and a
// default-window instance driven with random traffic against a scoreboard.
module tb_adder_error_monitor;
  import adder_mon_pkg::*;

  localparam int W     = 33;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: WINDOW=4
  logic             a_clear, a_in_valid, a_in_ready, a_rpt_valid, a_rpt_ready;
  logic [W-1:0]     a_approx, a_exact, a_max;
  logic [CNT_W-1:0] a_samples, a_errors;
  logic [ACC_W-1:0] a_sum;

  // instance b: WINDOW=4, ACC_W=34
  logic             b_clear, b_in_valid, b_in_ready, b_rpt_valid, b_rpt_ready;
  logic [W-1:0]     b_approx, b_exact, b_max;
  logic [CNT_W-1:0] b_samples, b_errors;
  logic [33:0]      b_sum;

  // instance c: WINDOW=1024
  logic             c_clear, c_in_valid, c_in_ready, c_rpt_valid, c_rpt_ready;
  logic [W-1:0]     c_approx, c_exact, c_max;
  logic [CNT_W-1:0] c_samples, c_errors;
  logic [ACC_W-1:0] c_sum;

  adder_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W), .WINDOW(4)) dut (
    .clk(clk), .rst(rst), .clear(a_clear),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .approx_sum(a_approx), .exact_sum(a_exact),
    .rpt_valid(a_rpt_valid), .rpt_ready(a_rpt_ready),
    .rpt_samples(a_samples), .rpt_errors(a_errors),
    .rpt_max_ed(a_max), .rpt_sum_ed(a_sum)
  );

  adder_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(34), .WINDOW(4)) dut_sat (
    .clk(clk), .rst(rst), .clear(b_clear),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .approx_sum(b_approx), .exact_sum(b_exact),
    .rpt_valid(b_rpt_valid), .rpt_ready(b_rpt_ready),
    .rpt_samples(b_samples), .rpt_errors(b_errors),
    .rpt_max_ed(b_max), .rpt_sum_ed(b_sum)
  );

  adder_error_monitor #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W), .WINDOW(1024)) dut_big (
    .clk(clk), .rst(rst), .clear(c_clear),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .approx_sum(c_approx), .exact_sum(c_exact),
    .rpt_valid(c_rpt_valid), .rpt_ready(c_rpt_ready),
    .rpt_samples(c_samples), .rpt_errors(c_errors),
    .rpt_max_ed(c_max), .rpt_sum_ed(c_sum)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [W-1:0] ap, input logic [W-1:0] ex);
    a_in_valid = 1'b1;
    a_approx   = ap;
    a_exact    = ex;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic chk_a_rpt(input string tag, input logic [63:0] s, input logic [63:0] e,
                           input logic [63:0] mx, input logic [63:0] sm);
    chk({tag, "_valid"},   64'(a_rpt_valid), 64'd1);
    chk({tag, "_samples"}, 64'(a_samples),   s);
    chk({tag, "_errors"},  64'(a_errors),    e);
    chk({tag, "_max"},     64'(a_max),       mx);
    chk({tag, "_sum"},     64'(a_sum),       sm);
  endtask

  // scoreboard state for the random run
  rpt_rec_t      exp_q[$];
  rpt_rec_t      m;
  rpt_rec_t      hd;
  logic [W-1:0]  ed;
  logic [W-1:0]  mask;
  int            acc_n;
  int            cyc;
  int            n_rpt;

  task automatic check_c_handshake();
    if (c_rpt_valid && c_rpt_ready) begin
      chk("t6_rpt_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        hd = exp_q.pop_front();
        chk("t6_samples", 64'(c_samples), 64'(hd.samples));
        chk("t6_errors",  64'(c_errors),  64'(hd.errors));
        chk("t6_max",     64'(c_max),     64'(hd.max_ed));
        chk("t6_sum",     64'(c_sum),     64'(hd.sum_ed));
      end
      n_rpt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    a_clear = 1'b0; a_in_valid = 1'b0; a_rpt_ready = 1'b1; a_approx = '0; a_exact = '0;
    b_clear = 1'b0; b_in_valid = 1'b0; b_rpt_ready = 1'b1; b_approx = '0; b_exact = '0;
    c_clear = 1'b0; c_in_valid = 1'b0; c_rpt_ready = 1'b1; c_approx = '0; c_exact = '0;

    // reset state
    tick();
    tick();
    chk("rst_in_ready",  64'(a_in_ready),  64'd0);
    chk("rst_rpt_valid", 64'(a_rpt_valid), 64'd0);
    chk("rst_samples",   64'(a_samples),   64'd0);
    chk("rst_errors",    64'(a_errors),    64'd0);
    chk("rst_max",       64'(a_max),       64'd0);
    chk("rst_sum",       64'(a_sum),       64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    tick();

    // 1: clean window, report two cycles after the 4th accept, one cycle wide
    for (int i = 0; i < 4; i++) send_a(33'd5, 33'd5);
    chk("t1_not_yet", 64'(a_rpt_valid), 64'd0);
    tick();
    chk_a_rpt("t1", 64'd4, 64'd0, 64'd0, 64'd0);
    tick();
    chk("t1_one_cycle", 64'(a_rpt_valid), 64'd0);

    // 2: mixed error distances incl. full-scale
    send_a(33'd10, 33'd7);
    send_a(33'd7, 33'd10);
    send_a(33'd0, 33'h1_FFFF_FFFF);
    send_a(33'd3, 33'd3);
    tick();
    chk_a_rpt("t2", 64'd4, 64'd3, 64'h1_FFFF_FFFF, 64'h2_0000_0005);
    tick();

    // 3: back-pressure on the report holds it and stalls input
    a_rpt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(33'd6, 33'd1);
    tick();
    a_in_valid = 1'b1; a_approx = 33'd1; a_exact = 33'd0;
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall_in_ready", 64'(a_in_ready), 64'd0);
      chk_a_rpt("t3_hold", 64'd4, 64'd4, 64'd5, 64'd20);
      tick();
    end
    a_in_valid = 1'b0;
    a_rpt_ready = 1'b1;
    #1;
    chk("t3_release_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("t3_dropped", 64'(a_rpt_valid), 64'd0);
    chk("t3_in_ready", 64'(a_in_ready), 64'd1);
    send_a(33'd2, 33'd0);
    for (int i = 0; i < 3; i++) send_a(33'd0, 33'd0);
    tick();
    chk_a_rpt("t3_next", 64'd4, 64'd1, 64'd2, 64'd2);
    tick();

    // 5a: clear mid-window discards partial stats and the clear-cycle sample
    for (int i = 0; i < 3; i++) send_a(33'd9, 33'd1);
    a_clear = 1'b1; a_in_valid = 1'b1; a_approx = 33'd100; a_exact = 33'd0;
    #1;
    chk("t5_clear_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    a_clear = 1'b0; a_in_valid = 1'b0;
    chk("t5_clear_no_rpt", 64'(a_rpt_valid), 64'd0);
    for (int i = 0; i < 4; i++) send_a(33'd7, 33'd7);
    chk("t5_clear_no_early", 64'(a_rpt_valid), 64'd0);
    tick();
    chk_a_rpt("t5_clear", 64'd4, 64'd0, 64'd0, 64'd0);
    tick();

    // 5b: same with rst
    for (int i = 0; i < 3; i++) send_a(33'd9, 33'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 64'(a_in_ready), 64'd0);
    tick();
    rst = 1'b0;
    chk("t5_rst_no_rpt", 64'(a_rpt_valid), 64'd0);
    for (int i = 0; i < 4; i++) send_a(33'd7, 33'd7);
    chk("t5_rst_no_early", 64'(a_rpt_valid), 64'd0);
    tick();
    chk_a_rpt("t5_rst", 64'd4, 64'd0, 64'd0, 64'd0);
    tick();

    // 4: narrow accumulator saturates
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1'b1; b_approx = 33'h1_FFFF_FFFF; b_exact = 33'd0;
      tick();
    end
    b_in_valid = 1'b0;
    tick();
    chk("t4_valid",   64'(b_rpt_valid), 64'd1);
    chk("t4_samples", 64'(b_samples),   64'd4);
    chk("t4_errors",  64'(b_errors),    64'd4);
    chk("t4_max",     64'(b_max),       64'h1_FFFF_FFFF);
    chk("t4_sum_sat", 64'(b_sum),       64'h3_FFFF_FFFF);
    tick();

    // 6: random traffic, WINDOW=1024, 30000 samples -> 29 full windows
    m = '0; acc_n = 0; cyc = 0; n_rpt = 0;
    while (acc_n < 30000 && cyc < 60000) begin
      c_rpt_ready = ($urandom_range(3) != 0);
      c_in_valid  = ($urandom_range(9) != 0);
      c_exact     = {1'($urandom_range(1)), 32'($urandom)};
      mask        = 33'($urandom & ((32'd1 << $urandom_range(8)) - 32'd1));
      c_approx    = c_exact ^ mask;
      #1;
      check_c_handshake();
      if (c_in_valid && c_in_ready) begin
        ed = (c_approx > c_exact) ? c_approx - c_exact : c_exact - c_approx;
        m.samples = m.samples + 1;
        if (ed != 0) m.errors = m.errors + 1;
        if (ed > m.max_ed) m.max_ed = ed;
        m.sum_ed = m.sum_ed + 48'(ed);
        if (m.samples == 1024) begin
          exp_q.push_back(m);
          m = '0;
        end
        acc_n++;
      end
      tick();
      cyc++;
    end
    c_in_valid = 1'b0;
    c_rpt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_c_handshake();
      tick();
    end
    chk("t6_accepted",  64'(acc_n),        64'd30000);
    chk("t6_reports",   64'(n_rpt),        64'd29);
    chk("t6_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
